// File: rtl/dmux_stream_issue.sv
// Valid/ready front end for the pipelined demux: one skid register, per-output credit
// gating, and a one-hot valid strobe delayed to match the demux output latency.
module dmux_stream_issue #(
    parameter int WIDTH        = 1,
    parameter int OUTPUT_COUNT = 2,
    parameter int DMUX_LATENCY = 0,
    parameter int CREDITS      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [$clog2(OUTPUT_COUNT)-1:0] s_sel,
    input  logic [WIDTH-1:0]                s_data,
    output logic [$clog2(OUTPUT_COUNT)-1:0] dmux_sel,
    output logic [WIDTH-1:0]                dmux_in,
    output logic [OUTPUT_COUNT-1:0]         out_valid,
    input  logic [OUTPUT_COUNT-1:0]         credit_return,
    output logic                            err_bad_sel,
    output logic                            err_credit_ovf
);
    localparam int SW = $clog2(OUTPUT_COUNT);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int SEL_SPAN = 1 << SW;

    logic                            hold_valid_reg;
    logic [SW-1:0]                   hold_sel_reg;
    logic [WIDTH-1:0]                hold_data_reg;
    logic [SW-1:0]                   dmux_sel_reg;
    logic [WIDTH-1:0]                dmux_in_reg;
    logic [DMUX_LATENCY:0]           vp_valid_reg;
    logic [DMUX_LATENCY:0][SW-1:0]   vp_sel_reg;
    logic [OUTPUT_COUNT-1:0][CW-1:0] credit_reg;
    logic [OUTPUT_COUNT-1:0][CW-1:0] credit_next;
    logic                            err_bad_sel_reg;
    logic                            err_credit_ovf_reg;

    logic                    sel_ok;
    logic                    issue;
    logic                    drop;
    logic                    accept;
    logic [SEL_SPAN-1:0]     credit_nz;
    logic [OUTPUT_COUNT-1:0] issue_vec;
    logic [OUTPUT_COUNT-1:0] ovf_vec;

    // Non-existent select codes map to "no credit" so the mux index never runs off the end.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_credit_nz
            if (gi < OUTPUT_COUNT) begin : g_real
                assign credit_nz[gi] = (credit_reg[gi] != '0);
            end else begin : g_pad
                assign credit_nz[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_out
            assign issue_vec[gi] = issue && (hold_sel_reg == SW'(gi));
            assign out_valid[gi] = vp_valid_reg[DMUX_LATENCY]
                                   && (vp_sel_reg[DMUX_LATENCY] == SW'(gi));
        end
    endgenerate

    assign sel_ok  = (32'(hold_sel_reg) < 32'(OUTPUT_COUNT));
    assign issue   = hold_valid_reg && sel_ok && credit_nz[hold_sel_reg];
    assign drop    = hold_valid_reg && !sel_ok;
    assign s_ready = !hold_valid_reg || issue || drop;
    assign accept  = s_valid && s_ready;

    always_comb begin
        credit_next = credit_reg;
        ovf_vec     = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            if (issue_vec[i] && !credit_return[i]) begin
                credit_next[i] = credit_reg[i] - CW'(1);
            end else if (!issue_vec[i] && credit_return[i]) begin
                if (credit_reg[i] == CW'(CREDITS)) begin
                    ovf_vec[i] = 1'b1;
                end else begin
                    credit_next[i] = credit_reg[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_reg <= 1'b0;
            hold_sel_reg   <= '0;
            hold_data_reg  <= '0;
        end else if (accept) begin
            hold_valid_reg <= 1'b1;
            hold_sel_reg   <= s_sel;
            hold_data_reg  <= s_data;
        end else if (issue || drop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    // dmux_in idles at zero; dmux_sel keeps its last value between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmux_sel_reg <= '0;
            dmux_in_reg  <= '0;
        end else if (issue) begin
            dmux_sel_reg <= hold_sel_reg;
            dmux_in_reg  <= hold_data_reg;
        end else begin
            dmux_in_reg  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp_valid_reg <= '0;
            vp_sel_reg   <= '0;
        end else begin
            vp_valid_reg[0] <= issue;
            vp_sel_reg[0]   <= hold_sel_reg;
            for (int k = 1; k <= DMUX_LATENCY; k++) begin
                vp_valid_reg[k] <= vp_valid_reg[k-1];
                vp_sel_reg[k]   <= vp_sel_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUTPUT_COUNT; i++) begin
                credit_reg[i] <= CW'(CREDITS);
            end
            err_bad_sel_reg    <= 1'b0;
            err_credit_ovf_reg <= 1'b0;
        end else begin
            credit_reg         <= credit_next;
            err_bad_sel_reg    <= err_bad_sel_reg || drop;
            err_credit_ovf_reg <= err_credit_ovf_reg || (|ovf_vec);
        end
    end

    assign dmux_sel       = dmux_sel_reg;
    assign dmux_in        = dmux_in_reg;
    assign err_bad_sel    = err_bad_sel_reg;
    assign err_credit_ovf = err_credit_ovf_reg;
endmodule
